axis_i2s_tx: RTL

I2S transmitter that accepts stereo samples on an AXI4-Stream slave port and serialises them as an I2S master (mclk, sclk, lrck, sdout) toward a DAC/codec. It is the playback counterpart of the team's I2S receiver. It uses the same 256-mclk frame, 64 sclk per frame and 64-bit sample format, so RX and TX can share one aclk and one codec. One sample is consumed per lrck frame through a single-entry holding register; underruns are flagged.

---
 rtl/axis_i2s_tx.sv | 109 ++++++++++
 1 files changed

// File: rtl/axis_i2s_tx.sv
// I2S master transmitter fed from an AXI4-Stream slave: 256 aclk per frame, 32 sclk per channel, one 64-bit stereo word per frame.
// Build option AXIS_I2S_TX_HOLD_LAST_EN: on underrun repeat the last loaded word instead of sending silence.
module axis_i2s_tx (
    input  logic        aclk,
    input  logic        resetn,
    input  logic [63:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic        mclk,
    output logic        sclk,
    output logic        lrck,
    output logic        sdout,
    output logic        underrun
);

    logic [7:0]  cnt_q, cnt_d;
    logic [63:0] hold_data_q, hold_data_d;
    logic        hold_valid_q, hold_valid_d;
    logic [63:0] sr_q, sr_d;
    logic        sdout_q, sdout_d;
    logic        underrun_q, underrun_d;
    logic [63:0] fill_word;
    logic        handshake;
    logic        frame_load;
    logic        sclk_fall;
    logic        unused_tlast;

`ifdef AXIS_I2S_TX_HOLD_LAST_EN
    logic [63:0] last_word_q, last_word_d;
    assign fill_word = last_word_q;
`else
    assign fill_word = 64'd0;
`endif

    assign unused_tlast  = s_axis_tlast;
    assign s_axis_tready = resetn & ~hold_valid_q;
    assign handshake     = s_axis_tvalid & s_axis_tready;
    assign frame_load    = (cnt_q == 8'hFF);
    assign sclk_fall     = (cnt_q[1:0] == 2'b11);

    assign mclk     = aclk;
    assign sclk     = cnt_q[1];
    assign lrck     = cnt_q[7];
    assign sdout    = sdout_q;
    assign underrun = underrun_q;

    always_comb begin
        cnt_d        = cnt_q + 8'd1;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        sr_d         = sr_q;
        sdout_d      = sdout_q;
        underrun_d   = 1'b0;
`ifdef AXIS_I2S_TX_HOLD_LAST_EN
        last_word_d  = last_word_q;
`endif
        // A handshake can only land while the holding register is empty, so it never collides with a load that empties it.
        if (handshake) begin
            hold_data_d  = s_axis_tdata;
            hold_valid_d = 1'b1;
        end
        if (sclk_fall) begin
            sdout_d = sr_q[63];
            sr_d    = {sr_q[62:0], 1'b0};
        end
        if (frame_load) begin
            if (hold_valid_q) begin
                sr_d         = hold_data_q;
                hold_valid_d = 1'b0;
`ifdef AXIS_I2S_TX_HOLD_LAST_EN
                last_word_d  = hold_data_q;
`endif
            end else begin
                sr_d       = fill_word;
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            cnt_q        <= 8'd0;
            hold_data_q  <= 64'd0;
            hold_valid_q <= 1'b0;
            sr_q         <= 64'd0;
            sdout_q      <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            sr_q         <= sr_d;
            sdout_q      <= sdout_d;
            underrun_q   <= underrun_d;
        end
    end

`ifdef AXIS_I2S_TX_HOLD_LAST_EN
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            last_word_q <= 64'd0;
        end else begin
            last_word_q <= last_word_d;
        end
    end
`endif

endmodule
